// File: rtl/pistorm_txn_queue.sv
// Posted-transaction queue: assembles Pi register writes into 68K bus cycles
// and buffers them for the bus engine, capturing read data on completion.
module pistorm_txn_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          PI_CLK,
    input  logic          RESET_n,
    input  logic          wr_strobe,
    input  logic [1:0]    wr_reg,
    input  logic [15:0]   wr_data,
    input  logic          flush,
    input  logic          clr_err,
    output logic          op_valid,
    output logic [23:0]   op_addr,
    output logic [15:0]   op_data,
    output logic          op_rw,
    output logic          op_uds_n,
    output logic          op_lds_n,
    input  logic          op_ack,
    input  logic [15:0]   op_rd_data,
    output logic [15:0]   rd_data,
    output logic          rd_ready,
    input  logic          rd_taken,
    output logic          busy,
    output logic [AW:0]   level,
    output logic          overflow
);

    typedef struct packed {
        logic [23:0] addr;
        logic [15:0] data;
        logic        rw;
        logic        uds_n;
        logic        lds_n;
    } entry_t;

    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);
    localparam entry_t ENTRY_RST = '{addr: '0, data: '0, rw: 1'b1, uds_n: 1'b1, lds_n: 1'b1};

    entry_t          mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]     level_q, level_d;
    logic            busy_q;
    logic            ovf_q, ovf_d;
    logic [15:0]     data_hold_q, addr_lo_q;
    logic [15:0]     rd_data_q, rd_data_d;
    logic            rd_ready_q, rd_ready_d;

    logic            commit, do_ack, do_push, ovf_set;
    entry_t          head, new_entry;
    logic            size_byte, a0;

    assign head      = mem_q[rd_ptr_q];
    assign commit    = wr_strobe && (wr_reg == 2'd2);
    assign do_ack    = op_ack && busy_q && !flush;
    // A pop in the same cycle frees the head slot, so a full queue still accepts.
    assign do_push   = commit && !flush && ((level_q != LVL_FULL) || do_ack);
    assign ovf_set   = commit && !flush && (level_q == LVL_FULL) && !do_ack;

    assign size_byte = wr_data[8];
    assign a0        = addr_lo_q[0];

    always_comb begin
        new_entry       = ENTRY_RST;
        new_entry.addr  = {wr_data[7:0], addr_lo_q};
        new_entry.data  = data_hold_q;
        new_entry.rw    = wr_data[9];
        new_entry.uds_n = size_byte ? a0 : 1'b0;
        new_entry.lds_n = size_byte ? !a0 : 1'b0;
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        ovf_d      = ovf_q;
        rd_data_d  = rd_data_q;
        rd_ready_d = rd_ready_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_ack)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (do_push && !do_ack)      level_d = level_q + (AW+1)'(1);
            else if (do_ack && !do_push) level_d = level_q - (AW+1)'(1);
        end

        if (ovf_set)      ovf_d = 1'b1;
        else if (clr_err) ovf_d = 1'b0;

        if (do_ack && head.rw) begin
            rd_data_d  = op_rd_data;
            rd_ready_d = 1'b1;
        end else if (rd_taken) begin
            rd_ready_d = 1'b0;
        end
    end

    always_ff @(posedge PI_CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= ENTRY_RST;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            busy_q      <= 1'b0;
            ovf_q       <= 1'b0;
            data_hold_q <= '0;
            addr_lo_q   <= '0;
            rd_data_q   <= '0;
            rd_ready_q  <= 1'b0;
        end else begin
            if (do_push) mem_q[wr_ptr_q] <= new_entry;
            if (wr_strobe && wr_reg == 2'd0) data_hold_q <= wr_data;
            if (wr_strobe && wr_reg == 2'd1) addr_lo_q   <= wr_data;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            busy_q     <= (level_d != '0);
            ovf_q      <= ovf_d;
            rd_data_q  <= rd_data_d;
            rd_ready_q <= rd_ready_d;
        end
    end

    assign op_valid = busy_q;
    assign op_addr  = head.addr;
    assign op_data  = head.data;
    assign op_rw    = head.rw;
    assign op_uds_n = head.uds_n;
    assign op_lds_n = head.lds_n;
    assign rd_data  = rd_data_q;
    assign rd_ready = rd_ready_q;
    assign busy     = busy_q;
    assign level    = level_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_pistorm_txn_queue.sv
// Scoreboard bench for pistorm_txn_queue: expected entries are queued at
// commit and compared against the head when the bench acknowledges it.
module tb_pistorm_txn_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          PI_CLK, RESET_n;
    logic          wr_strobe;
    logic [1:0]    wr_reg;
    logic [15:0]   wr_data;
    logic          flush, clr_err;
    logic          op_valid;
    logic [23:0]   op_addr;
    logic [15:0]   op_data;
    logic          op_rw, op_uds_n, op_lds_n;
    logic          op_ack;
    logic [15:0]   op_rd_data;
    logic [15:0]   rd_data;
    logic          rd_ready, rd_taken;
    logic          busy;
    logic [AW:0]   level;
    logic          overflow;

    pistorm_txn_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .PI_CLK(PI_CLK), .RESET_n(RESET_n),
        .wr_strobe(wr_strobe), .wr_reg(wr_reg), .wr_data(wr_data),
        .flush(flush), .clr_err(clr_err),
        .op_valid(op_valid), .op_addr(op_addr), .op_data(op_data),
        .op_rw(op_rw), .op_uds_n(op_uds_n), .op_lds_n(op_lds_n),
        .op_ack(op_ack), .op_rd_data(op_rd_data),
        .rd_data(rd_data), .rd_ready(rd_ready), .rd_taken(rd_taken),
        .busy(busy), .level(level), .overflow(overflow)
    );

    initial PI_CLK = 1'b0;
    always #5 PI_CLK = ~PI_CLK;

    typedef struct {
        logic [23:0] addr;
        logic [15:0] data;
        logic        rw;
        logic        uds_n;
        logic        lds_n;
    } ent_t;

    ent_t        sb[$];
    logic [15:0] m_hold, m_lo, m_rd_data;
    logic        m_rd_ready, m_ovf;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock of stimulus; entered and left on a falling edge.
    task automatic cyc(input logic stb, input logic [1:0] r, input logic [15:0] d,
                       input logic ack, input logic [15:0] rdv,
                       input logic fl, input logic clr, input logic tk);
        wr_strobe = stb; wr_reg = r; wr_data = d;
        op_ack = ack; op_rd_data = rdv; flush = fl; clr_err = clr; rd_taken = tk;
        @(negedge PI_CLK);
        wr_strobe = 1'b0; wr_reg = 2'd0; wr_data = '0;
        op_ack = 1'b0; op_rd_data = '0; flush = 1'b0; clr_err = 1'b0; rd_taken = 1'b0;
    endtask

    function automatic ent_t mk(input logic [23:0] a, input logic [15:0] d,
                                input logic rw, input logic byt);
        ent_t e;
        e.addr  = a;
        e.data  = d;
        e.rw    = rw;
        e.uds_n = byt ? a[0] : 1'b0;
        e.lds_n = byt ? !a[0] : 1'b0;
        return e;
    endfunction

    task automatic check_head(input string tag);
        if (sb.size() == 0) begin
            check({tag, ".valid"}, {31'b0, op_valid}, 32'd0);
        end else begin
            check({tag, ".valid"}, {31'b0, op_valid}, 32'd1);
            check({tag, ".addr"},  {8'b0, op_addr},   {8'b0, sb[0].addr});
            check({tag, ".data"},  {16'b0, op_data},  {16'b0, sb[0].data});
            check({tag, ".rw"},    {31'b0, op_rw},    {31'b0, sb[0].rw});
            check({tag, ".uds"},   {31'b0, op_uds_n}, {31'b0, sb[0].uds_n});
            check({tag, ".lds"},   {31'b0, op_lds_n}, {31'b0, sb[0].lds_n});
        end
    endtask

    task automatic check_status(input string tag);
        check({tag, ".level"},  {29'b0, level},      sb.size());
        check({tag, ".busy"},   {31'b0, busy},       {31'b0, sb.size() != 0});
        check({tag, ".ovf"},    {31'b0, overflow},   {31'b0, m_ovf});
        check({tag, ".rdy"},    {31'b0, rd_ready},   {31'b0, m_rd_ready});
        check({tag, ".rdata"},  {16'b0, rd_data},    {16'b0, m_rd_data});
    endtask

    task automatic load_regs(input logic [23:0] a, input logic [15:0] d);
        cyc(1'b1, 2'd0, d, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 2'd1, a[15:0], 1'b0, '0, 1'b0, 1'b0, 1'b0);
        m_hold = d;
        m_lo   = a[15:0];
    endtask

    // Full commit sequence; optional same-cycle ack of the current head.
    task automatic commit(input logic [23:0] a, input logic [15:0] d, input logic rw,
                          input logic byt, input logic ack, input logic [15:0] rdv);
        ent_t popped;
        load_regs(a, d);
        if (ack) check_head("cmt_ack_head");
        cyc(1'b1, 2'd2, {6'b0, rw, byt, a[23:16]}, ack, rdv, 1'b0, 1'b0, 1'b0);
        if (ack && sb.size() != 0) begin
            popped = sb.pop_front();
            if (popped.rw) begin m_rd_data = rdv; m_rd_ready = 1'b1; end
        end
        if (sb.size() < DEPTH) sb.push_back(mk(a, m_hold, rw, byt));
        else m_ovf = 1'b1;
    endtask

    task automatic ack_head(input logic [15:0] rdv, input logic tk);
        ent_t popped;
        check_head("ack_head");
        cyc(1'b0, 2'd0, '0, 1'b1, rdv, 1'b0, 1'b0, tk);
        if (sb.size() != 0) begin
            popped = sb.pop_front();
            if (popped.rw) begin m_rd_data = rdv; m_rd_ready = 1'b1; end
            else if (tk) m_rd_ready = 1'b0;
        end else if (tk) m_rd_ready = 1'b0;
    endtask

    task automatic model_reset();
        sb.delete();
        m_hold = '0; m_lo = '0; m_rd_data = '0; m_rd_ready = 1'b0; m_ovf = 1'b0;
    endtask

    initial begin
        RESET_n = 1'b0;
        wr_strobe = 1'b0; wr_reg = '0; wr_data = '0; flush = 1'b0; clr_err = 1'b0;
        op_ack = 1'b0; op_rd_data = '0; rd_taken = 1'b0;
        model_reset();
        repeat (3) @(negedge PI_CLK);
        RESET_n = 1'b1;
        @(negedge PI_CLK);

        check_head("rst");
        check({"rst.addr"}, {8'b0, op_addr}, 32'h0);
        check({"rst.rw"}, {31'b0, op_rw}, 32'd1);
        check({"rst.uds"}, {31'b0, op_uds_n}, 32'd1);
        check({"rst.lds"}, {31'b0, op_lds_n}, 32'd1);
        check_status("rst");

        // Word write
        commit(24'hAB1234, 16'hBEEF, 1'b0, 1'b0, 1'b0, '0);
        check_head("word");
        check_status("word");
        ack_head('0, 1'b0);
        check_head("word_pop");
        check_status("word_pop");

        // Byte read at odd address, then read consumed
        commit(24'h000001, 16'h1111, 1'b1, 1'b1, 1'b0, '0);
        check_head("bread");
        ack_head(16'h00C5, 1'b0);
        check_status("bread_cap");
        cyc(1'b0, 2'd0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        m_rd_ready = 1'b0;
        check_status("bread_taken");

        // Byte read even address; capture and rd_taken in the same cycle
        commit(24'h123456, 16'h2222, 1'b1, 1'b1, 1'b0, '0);
        check_head("bread_even");
        ack_head(16'h005A, 1'b1);
        check_status("cap_vs_taken");
        cyc(1'b0, 2'd0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        m_rd_ready = 1'b0;

        // Register 3 writes are ignored
        cyc(1'b1, 2'd3, 16'hFFFF, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        check_status("reg3");

        // Fill, overflow, drain, clear error
        for (int i = 0; i < DEPTH; i++)
            commit(24'h100000 + 24'(i * 2), 16'h3000 + 16'(i), 1'b0, 1'b0, 1'b0, '0);
        check_status("full");
        commit(24'h1FFFFE, 16'h3FFF, 1'b0, 1'b0, 1'b0, '0);
        check_status("overflow");
        while (sb.size() != 0) ack_head('0, 1'b0);
        check_head("drained");
        check_status("drained");
        cyc(1'b0, 2'd0, '0, 1'b1, 16'h9999, 1'b0, 1'b1, 1'b0);
        m_ovf = 1'b0;
        check_status("clr_err_empty_ack");

        // Full plus simultaneous commit and ack
        for (int i = 0; i < DEPTH; i++)
            commit(24'h200000 + 24'(i * 2), 16'h4000 + 16'(i), 1'b0, 1'b0, 1'b0, '0);
        commit(24'h2000F0, 16'h40F0, 1'b0, 1'b0, 1'b1, '0);
        check_status("full_cmt_ack");
        while (sb.size() != 0) ack_head('0, 1'b0);

        // Ten entries through the queue to wrap the pointers
        for (int i = 0; i < 10; i++) begin
            commit(24'h300000 + 24'(i * 4), 16'h5000 + 16'(i), i[0], i[1], 1'b0, 16'h6000 + 16'(i));
            if (sb.size() >= 3) ack_head(16'h7000 + 16'(i), 1'b0);
        end
        while (sb.size() != 0) ack_head(16'h7F00, 1'b0);
        check_status("wrap_done");

        // Level 2 then flush with commit and ack in the same cycle
        commit(24'h400000, 16'h8000, 1'b1, 1'b0, 1'b0, '0);
        commit(24'h400002, 16'h8001, 1'b0, 1'b0, 1'b0, '0);
        check_status("pre_flush");
        load_regs(24'h400004, 16'h8002);
        cyc(1'b1, 2'd2, 16'h0040, 1'b1, 16'hDEAD, 1'b1, 1'b0, 1'b0);
        sb.delete();
        check_head("flush");
        check_status("flush");

        // Assembly registers survive flush: ADDR_HI alone reuses DATA/ADDR_LO
        cyc(1'b1, 2'd2, 16'h0041, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        sb.push_back(mk({8'h41, m_lo}, m_hold, 1'b0, 1'b0));
        check_head("post_flush");
        ack_head('0, 1'b0);

        // Level 3 then asynchronous reset between edges
        for (int i = 0; i < 3; i++)
            commit(24'h500000 + 24'(i * 2), 16'h9000 + 16'(i), 1'b1, 1'b0, 1'b0, '0);
        check_status("pre_reset");
        #2 RESET_n = 1'b0;
        #1;
        model_reset();
        check_head("async_rst");
        check({"async_rst.rw"}, {31'b0, op_rw}, 32'd1);
        check({"async_rst.uds"}, {31'b0, op_uds_n}, 32'd1);
        check_status("async_rst");
        @(negedge PI_CLK);
        RESET_n = 1'b1;
        @(negedge PI_CLK);
        commit(24'h600000, 16'hA000, 1'b0, 1'b0, 1'b0, '0);
        check_head("post_reset");
        check_status("post_reset");
        ack_head('0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
